alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage directly downstream of the ALU logic units (and16 and its
//  siblings). It captures the 16-bit combinational result together with its op tag and
//  derives the zero, negative and parity flags. Results are presented to the consumer
//  (register-file write-back or test harness) through a valid/ready handshake. A 2-entry
//  skid buffer lets the ALU keep issuing for one cycle after the consumer stalls.
// PARAMETERS
//  WIDTH     16  data width of result bus
//  OP_W      2   width of op tag carried alongside result
//  CNT_W     16  width of accepted-result counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous reset, active-low
//  in_valid   in   1       ALU result on in_y/in_op is valid this cycle
//  in_ready   out  1       stage can accept (count < 2 and rst_n high)
//  in_y       in   WIDTH   ALU result
//  in_op      in   OP_W    op tag (OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3)
//  out_valid  out  1       head entry valid
//  out_ready  in   1       consumer accepts head this cycle
//  out_y      out  WIDTH   head result
//  out_op     out  OP_W    head op tag
//  out_zero   out  1       head result == 0
//  out_neg    out  1       head result MSB
//  out_parity out  1       XOR-reduce of head result (1 = odd number of ones)
//  out_cnt    out  CNT_W   count of results accepted on input since reset
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): count=0, both entries cleared, out_valid=0,
//    out_y=0, out_op=0, flags=0, out_cnt=0. in_ready=0 while rst_n low (combinational gate).
//    Reset mid-operation discards all buffered entries; no partial output follows.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; count in {0,1,2}.
//  - in_ready = rst_n & (count != 2); derived from registered count only, never from out_ready.
//  - out_valid = (count != 0). Head = entry0; entry1 is the skid slot.
//  - Latency: push at edge N -> out_valid=1 with that data after edge N (visible cycle N+1).
//  - Flags are computed from in_y at capture and stored with the entry, not recomputed
//    at the output.
//  - count 0: push -> entry0, count=1.
//  - count 1: push only -> entry1, count=2. Pop only -> count=0.
//    Push and pop together -> entry0 <= new data, count stays 1.
//  - count 2: no push possible. Pop -> entry0 <= entry1, count=1.
//  - Entry order is strict FIFO; no result is dropped or duplicated.
//  - out_cnt increments by 1 on each push and wraps modulo 2^CNT_W (FFFF -> 0000).
//  - in_valid while in_ready=0: ignored; the producer must hold data (AXI-style rules).
//  - Output regs hold their value while out_valid=1 and out_ready=0.
//  - Outputs when count=0: out_y/out_op/flags hold last popped value; consumers qualify
//    with out_valid.
// STRUCTURE
//  - Package alu_pkg: WIDTH default, op_t enum (OP_AND..OP_NOT), flags_t struct
//    {zero, neg, parity}, entry_t struct {y, op, flags}.
//  - Sub-module alu_flag_calc (combinational: y -> flags_t) instantiated on the input path.
//    Reused by other ALU stages.
//  - Top: two entry_t registers, 2-bit count, out_cnt register.
// TESTING
//  1. rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_cnt=0, outputs 0.
//  2. in_y=FFFF&AAAA=AAAA, op=AND, out_ready=1 -> next cycle out_y=AAAA, neg=1, zero=0,
//     parity=0, out_cnt=1.
//  3. in_y=5555&AAAA=0000 -> out_y=0000, zero=1, neg=0, parity=0. in_y=0001 -> parity=1.
//  4. out_ready=0, push 1111,2222,3333 back-to-back -> in_ready=0 after 2nd push; 3333 held.
//     Release out_ready -> pops 1111,2222,3333 in order, no loss; out_cnt=3.
//  5. count=1, push and pop in same cycle, over 8 streaming cycles -> count stays 1,
//     one result per cycle, in_ready=1 throughout.
//  6. Fill to count=2, assert rst_n=0 one cycle -> out_valid=0, buffer empty. Preload
//     out_cnt=FFFF via 65535 pushes, push once -> out_cnt=0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: op tags, result flags and buffered entries.
package alu_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOT = 2'd3
  } op_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic parity;
  } flags_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    op_t              op;
    flags_t           flags;
  } entry_t;

  localparam entry_t ENTRY_RST = '{y: '0, op: OP_AND, flags: '0};

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational zero/negative/parity flag derivation for an ALU result word.
module alu_flag_calc
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] i_y,
  output flags_t           o_flags
);

  always_comb begin
    o_flags        = '0;
    o_flags.zero   = (i_y == '0);
    o_flags.neg    = i_y[WIDTH-1];
    o_flags.parity = ^i_y;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer with stored flags and an accepted-result
// counter, presented through a valid/ready handshake.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_y,
  input  logic [OP_W-1:0]  i_in_op,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_y,
  output logic [OP_W-1:0]  o_out_op,
  output logic             o_out_zero,
  output logic             o_out_neg,
  output logic             o_out_parity,
  output logic [CNT_W-1:0] o_out_cnt
);

  entry_t           r_e0, r_e1;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_cnt;

  entry_t           w_e0_nxt, w_e1_nxt, w_new;
  logic [1:0]       w_count_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  flags_t           w_flags;
  logic             w_push, w_pop;

  alu_flag_calc u_flag_calc (
    .i_y     (i_in_y),
    .o_flags (w_flags)
  );

  // Ready depends only on registered occupancy so the producer never sees a path from
  // the consumer's ready.
  assign o_in_ready  = i_rst_n & (r_count != 2'd2);
  assign o_out_valid = (r_count != 2'd0);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  always_comb begin
    w_new       = ENTRY_RST;
    w_new.y     = i_in_y;
    w_new.op    = op_t'(i_in_op);
    w_new.flags = w_flags;
  end

  always_comb begin
    w_count_nxt = r_count;
    w_e0_nxt    = r_e0;
    w_e1_nxt    = r_e1;
    unique case (r_count)
      2'd0: begin
        if (w_push) begin
          w_e0_nxt    = w_new;
          w_count_nxt = 2'd1;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_e0_nxt = w_new;
        end else if (w_push) begin
          w_e1_nxt    = w_new;
          w_count_nxt = 2'd2;
        end else if (w_pop) begin
          w_count_nxt = 2'd0;
        end
      end
      2'd2: begin
        if (w_pop) begin
          w_e0_nxt    = r_e1;
          w_count_nxt = 2'd1;
        end
      end
      default: w_count_nxt = 2'd0;
    endcase
  end

  assign w_cnt_nxt = r_cnt + CNT_W'(w_push);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_e0    <= ENTRY_RST;
      r_e1    <= ENTRY_RST;
      r_count <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_e0    <= w_e0_nxt;
      r_e1    <= w_e1_nxt;
      r_count <= w_count_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Head entry drives the outputs directly; it keeps its last value once popped.
  assign o_out_y      = r_e0.y;
  assign o_out_op     = r_e0.op;
  assign o_out_zero   = r_e0.flags.zero;
  assign o_out_neg    = r_e0.flags.neg;
  assign o_out_parity = r_e0.flags.parity;
  assign o_out_cnt    = r_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: table-driven flag vectors plus directed
// sequences for stall, streaming, reset flush and counter wrap.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_y;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic [1:0]  out_op;
  logic        out_zero;
  logic        out_neg;
  logic        out_parity;
  logic [15:0] out_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = '0;

  typedef struct {
    logic [15:0] y;
    logic [1:0]  op;
    logic        zero;
    logic        neg;
    logic        parity;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  alu_result_stage #(.CNT_W(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_y       (in_y),
    .i_in_op      (in_op),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_y      (out_y),
    .o_out_op     (out_op),
    .o_out_zero   (out_zero),
    .o_out_neg    (out_neg),
    .o_out_parity (out_parity),
    .o_out_cnt    (out_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    // {y, op, zero, neg, parity}
    vecs[0] = '{16'hAAAA, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0001, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 2'd2, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFE, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0007, 2'd1, 1'b0, 1'b0, 1'b1};

    // Reset held with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1; in_y = 16'h1234; in_op = 2'd1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_cnt", 32'(out_cnt), 32'd0);
    check("reset out_y", 32'(out_y), 32'd0);
    check("reset out_op", 32'(out_op), 32'd0);
    check("reset flags", {29'd0, out_zero, out_neg, out_parity}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("idle out_valid", 32'(out_valid), 32'd0);

    // Flag vectors, one push per cycle with the consumer always ready
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_y = vecs[i].y; in_op = vecs[i].op;
      @(negedge clk);
      exp_cnt++;
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_y", i), 32'(out_y), 32'(vecs[i].y));
      check($sformatf("vec%0d out_op", i), 32'(out_op), 32'(vecs[i].op));
      check($sformatf("vec%0d flags", i), {29'd0, out_zero, out_neg, out_parity},
            {29'd0, vecs[i].zero, vecs[i].neg, vecs[i].parity});
      check($sformatf("vec%0d out_cnt", i), 32'(out_cnt), 32'(exp_cnt));
    end
    @(negedge clk);
    check("drain out_valid", 32'(out_valid), 32'd0);
    check("hold last popped", 32'(out_y), 32'h0007);

    // Stall: two entries fill the buffer, third is held by the producer
    out_ready = 1'b0;
    in_valid = 1'b1; in_y = 16'h1111; in_op = 2'd0;
    @(negedge clk);
    exp_cnt++;
    check("stall1 out_y", 32'(out_y), 32'h1111);
    check("stall1 in_ready", 32'(in_ready), 32'd1);
    in_y = 16'h2222;
    @(negedge clk);
    exp_cnt++;
    check("stall2 in_ready", 32'(in_ready), 32'd0);
    check("stall2 out_y", 32'(out_y), 32'h1111);
    in_y = 16'h3333;
    @(negedge clk);
    check("stall3 in_ready", 32'(in_ready), 32'd0);
    check("stall3 out_y held", 32'(out_y), 32'h1111);
    check("stall3 out_cnt", 32'(out_cnt), 32'(exp_cnt));
    out_ready = 1'b1;
    @(negedge clk);
    check("release pop2 out_y", 32'(out_y), 32'h2222);
    check("release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    exp_cnt++;
    in_valid = 1'b0;
    check("release pop3 out_y", 32'(out_y), 32'h3333);
    check("release out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("release empty", 32'(out_valid), 32'd0);
    check("release out_cnt", 32'(out_cnt), 32'(exp_cnt));

    // Streaming at count=1: simultaneous push and pop every cycle
    in_valid = 1'b1; in_y = 16'hA000; in_op = 2'd2;
    @(negedge clk);
    exp_cnt++;
    for (int i = 0; i < 8; i++) begin
      in_y = 16'h0100 + 16'(i);
      @(negedge clk);
      exp_cnt++;
      check($sformatf("stream%0d out_y", i), 32'(out_y), 32'h0100 + 32'(i));
      check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    check("stream out_cnt", 32'(out_cnt), 32'(exp_cnt));
    @(negedge clk);

    // Reset with a full buffer discards everything
    out_ready = 1'b0;
    in_valid = 1'b1; in_y = 16'hBEEF;
    @(negedge clk);
    in_y = 16'hCAFE;
    @(negedge clk);
    in_valid = 1'b0;
    check("full in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush out_cnt", 32'(out_cnt), 32'd0);
    check("flush out_y", 32'(out_y), 32'd0);
    check("flush in_ready low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("flush in_ready high", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("flush no partial", 32'(out_valid), 32'd0);

    // Counter wrap: 65535 pushes, then one more
    in_valid = 1'b1; in_y = 16'h1234; in_op = 2'd1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("wrap preload", 32'(out_cnt), 32'h0000FFFF);
    in_valid = 1'b1; in_y = 16'h4321;
    @(negedge clk);
    in_valid = 1'b0;
    check("wrap out_cnt", 32'(out_cnt), 32'd0);
    check("wrap out_y", 32'(out_y), 32'h4321);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
